// File: rtl/regfile_bypass.sv
// regfile_bypass
//   8 x WIDTH register file for the decode stage: two combinational read
//   ports, one write port, and write-before-read bypass so decode sees the
//   value writeback is committing in the same cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active low (0 = reset)
//   read1_reg   in   [2:0]        source index, port 1
//   read2_reg   in   [2:0]        source index, port 2
//   write_reg   in   [2:0]        destination index
//   write_data  in   [WIDTH-1:0]  data to write
//   write_en    in   write request this cycle
//   read1_data  out  [WIDTH-1:0]  entry[read1_reg], bypassed
//   read2_data  out  [WIDTH-1:0]  entry[read2_reg], bypassed
//   err         out  sticky flag: write_en was X/Z at a clock edge
module regfile_bypass #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       read1_reg,
    input  logic [2:0]       read2_reg,
    input  logic [2:0]       write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_en,
    output logic [WIDTH-1:0] read1_data,
    output logic [WIDTH-1:0] read2_data,
    output logic             err
);

    localparam int NUM_REGS = 8;
    localparam int NUM_RD   = 2;

    logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                           err_q, err_d;
    logic [NUM_REGS-1:0]            we_dec;
    logic [NUM_RD-1:0][2:0]         rd_idx;
    logic [NUM_RD-1:0][WIDTH-1:0]   rd_data;
    logic                           wen_unknown;

    // One-hot write enable: write_en gated with the 3-to-8 decode.
    always_comb begin
        we_dec = '0;
        if (write_en) we_dec[write_reg] = 1'b1;
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we_dec[i]) regs_d[i] = write_data;
        end
    end

    // Case-equality compare: only an X/Z write_en makes both tests true.
    // Synthesis treats !== as !=, so this reduces to constant 0.
    assign wen_unknown = (write_en !== 1'b0) && (write_en !== 1'b1);

    always_comb begin
        err_d = err_q | wen_unknown;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= {NUM_REGS{RST_VAL}};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    assign rd_idx[0] = read1_reg;
    assign rd_idx[1] = read2_reg;

    // Each read port bypasses independently. While rst is low the array is
    // already forced to RST_VAL; the explicit override keeps the bypass
    // path from leaking write_data during reset.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!rst)
                rd_data[p] = RST_VAL;
            else if (write_en && (rd_idx[p] == write_reg))
                rd_data[p] = write_data;
            else
                rd_data[p] = regs_q[rd_idx[p]];
        end
    end

    assign read1_data = rd_data[0];
    assign read2_data = rd_data[1];
    assign err        = err_q;

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  read1_reg, read2_reg, write_reg;
    logic [15:0] write_data;
    logic        write_en;
    logic [15:0] read1_data, read2_data;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: plain array of architectural register contents.
    logic [15:0] mdl [8];

    regfile_bypass #(.WIDTH(16), .RST_VAL(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .read1_reg (read1_reg),
        .read2_reg (read2_reg),
        .write_reg (write_reg),
        .write_data(write_data),
        .write_en  (write_en),
        .read1_data(read1_data),
        .read2_data(read2_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Expected read value: same-cycle write wins over stored contents.
    function automatic logic [15:0] exp_rd(input logic [2:0] r);
        if (!rst) return 16'h0000;
        if (write_en && r == write_reg) return write_data;
        return mdl[r];
    endfunction

    // Advance through one rising edge, committing the model write, and land
    // 1 time unit past the edge so inputs change away from it.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        end else if (write_en) begin
            mdl[write_reg] = write_data;
        end
        #1;
    endtask

    task automatic do_write(input logic [2:0] r, input logic [15:0] d);
        write_en = 1'b1; write_reg = r; write_data = d;
        step();
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        // Power-on reset state.
        for (int i = 0; i < 8; i++) begin
            read1_reg = 3'(i); read2_reg = 3'(7 - i); #1;
            vectors++;
            if (read1_data !== 16'h0000 || read2_data !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_init r%0d: got %h/%h want 0000", i, read1_data, read2_data);
            end
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 0", err);
        end
        @(negedge clk); rst = 1'b1;
        step();
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'hFFFF);
        // Mid-cycle async reset: all entries clear before any edge.
        #2; rst = 1'b0; #1;
        for (int i = 0; i < 8; i++) begin
            read1_reg = 3'(i); read2_reg = 3'(i); #0.1;
            vectors++;
            if (read1_data !== 16'h0000 || read2_data !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_async r%0d: got %h/%h want 0000", i, read1_data, read2_data);
            end
        end
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        @(negedge clk); rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 8; k++) do_write(3'(k), 16'(16'h1110 * k + k));
        for (int k = 0; k < 8; k++) begin
            read1_reg = 3'(k); read2_reg = 3'(7 - k); #1;
            vectors++;
            if (read1_data !== 16'(16'h1110 * k + k) ||
                read2_data !== 16'(16'h1110 * (7 - k) + (7 - k))) begin
                miscompares++;
                $display("FAIL write_read k%0d: got %h/%h want %h/%h", k, read1_data, read2_data,
                         16'(16'h1110 * k + k), 16'(16'h1110 * (7 - k) + (7 - k)));
            end
        end
    endtask

    task automatic test_bypass();
        do_write(3'd3, 16'h1234);
        read1_reg = 3'd3; read2_reg = 3'd3;
        write_en = 1'b1; write_reg = 3'd3; write_data = 16'hBEEF; #1;
        vectors++;
        if (read1_data !== 16'hBEEF || read2_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL bypass_same: got %h/%h want beef/beef", read1_data, read2_data);
        end
        step();
        write_en = 1'b0; #1;
        vectors++;
        if (read1_data !== 16'hBEEF || read2_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL bypass_next: got %h/%h want beef/beef", read1_data, read2_data);
        end
    endtask

    task automatic test_write_disabled();
        logic [15:0] old5;
        old5 = mdl[5];
        write_en = 1'b0; write_reg = 3'd5; write_data = 16'hAAAA; read1_reg = 3'd5; #1;
        vectors++;
        if (read1_data !== old5) begin
            miscompares++;
            $display("FAIL wdis_comb: got %h want %h", read1_data, old5);
        end
        step(); #1;
        vectors++;
        if (read1_data !== old5) begin
            miscompares++;
            $display("FAIL wdis_after: got %h want %h", read1_data, old5);
        end
    endtask

    task automatic test_mixed();
        do_write(3'd2, 16'h0042);
        write_en = 1'b1; write_reg = 3'd7; write_data = 16'h8001;
        read1_reg = 3'd7; read2_reg = 3'd2; #1;
        vectors++;
        if (read1_data !== 16'h8001 || read2_data !== 16'h0042) begin
            miscompares++;
            $display("FAIL mixed: got %h/%h want 8001/0042", read1_data, read2_data);
        end
        step();
        write_en = 1'b0;
    endtask

    task automatic test_reset_during_write();
        @(negedge clk);
        rst = 1'b0; write_en = 1'b1; write_reg = 3'd1; write_data = 16'h5555; read1_reg = 3'd1; #1;
        vectors++;
        if (read1_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_wr_nobypass: got %h want 0000", read1_data);
        end
        step();
        write_en = 1'b0;
        #2; rst = 1'b1;
        step(); #1;
        vectors++;
        if (read1_data !== 16'h0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wr_after: got %h err %b want 0000 err 0", read1_data, err);
        end
    endtask

    task automatic test_random();
        logic [15:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            write_en   = 1'($urandom_range(0, 1));
            write_reg  = 3'($urandom);
            write_data = 16'($urandom);
            read1_reg  = 3'($urandom);
            read2_reg  = ($urandom_range(0, 3) == 0) ? write_reg : 3'($urandom);
            #1;
            e1 = exp_rd(read1_reg);
            e2 = exp_rd(read2_reg);
            vectors++;
            if (read1_data !== e1 || read2_data !== e2 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL random n%0d: got %h/%h err %b want %h/%h err 0",
                         n, read1_data, read2_data, err, e1, e2);
            end
            step();
        end
        write_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; write_en = 1'b0; write_reg = '0; write_data = '0;
        read1_reg = '0; read2_reg = '0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        #3;
        test_reset();
        test_write_read();
        test_bypass();
        test_write_disabled();
        test_mixed();
        test_reset_during_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
